// File: rtl/riscv_mc_datapath_pkg.sv
// Shared encodings for the multicycle RV32I/RV32E datapath: ALU ops, immediate formats,
// mux selects, memory-interface states and the immediate decoder.
package riscv_mc_datapath_pkg;

   localparam int          XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_SLL    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_SLT    = 4'd8;
   localparam logic [3:0] ALU_SLTU   = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] ALU_A_PC    = 2'd0;
   localparam logic [1:0] ALU_A_OLDPC = 2'd1;
   localparam logic [1:0] ALU_A_REG   = 2'd2;

   localparam logic [1:0] ALU_B_REG  = 2'd0;
   localparam logic [1:0] ALU_B_IMM  = 2'd1;
   localparam logic [1:0] ALU_B_FOUR = 2'd2;

   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_MDR    = 2'd1;
   localparam logic [1:0] RES_ALU    = 2'd2;

   typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t;

   // Returns the 32-bit sign-extended immediate; callers widen it to XLEN.
   function automatic logic [31:0] imm_ext32(input logic [31:0] instr, input logic [2:0] sel);
      case (sel)
         IMM_I:   return {{20{instr[31]}}, instr[31:20]};
         IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   return {instr[31:12], 12'b0};
         IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: return {{20{instr[31]}}, instr[31:20]};
      endcase
   endfunction

endpackage

// File: rtl/riscv_mc_datapath_memif.sv
// Unified memory port: latches one request, holds it until the memory is ready,
// captures read data into MDR and pulses done for one cycle.
module riscv_mc_datapath_memif
   import riscv_mc_datapath_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req,
   input  logic            i_we,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_mdr,
   output logic            o_done,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   input  logic            i_mem_ready,
   input  logic [XLEN-1:0] i_mem_rdata
);

   mem_state_t state_q, state_d;

   always_comb begin
      // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         MEM_IDLE: if (i_req)       state_d = MEM_BUSY;
         MEM_BUSY: if (i_mem_ready) state_d = MEM_IDLE;
         default:                   state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: all state updates use non-blocking assignment so every register samples pre-edge values.
      if (i_rst) begin
         state_q     <= MEM_IDLE;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mdr       <= '0;
         o_done      <= 1'b0;
      end else begin
         state_q <= state_d;
         o_done  <= (state_q == MEM_BUSY) && i_mem_ready;
         if (state_q == MEM_IDLE && i_req) begin
            o_mem_we    <= i_we;
            o_mem_addr  <= i_addr;
            o_mem_wdata <= i_wdata;
         end
         if (state_q == MEM_BUSY && i_mem_ready && !o_mem_we)
            o_mdr <= i_mem_rdata;
      end
   end

   assign o_mem_req = (state_q == MEM_BUSY);

endmodule

// File: rtl/riscv_mc_datapath.sv
// Multicycle RV32I/RV32E datapath: shared ALU, architectural step registers (PC, OLDPC,
// IR, A, B, ALUOUT), GPR file and a unified memory port, sequenced by an external controller.
module riscv_mc_datapath
   import riscv_mc_datapath_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_dp_pc_wr_en,
   input  logic            i_dp_ir_wr_en,
   input  logic            i_dp_addr_sel,
   input  logic            i_dp_mem_req,
   input  logic            i_dp_mem_we,
   input  logic [2:0]      i_dp_src_imm,
   input  logic [1:0]      i_dp_src_alu_a,
   input  logic [1:0]      i_dp_src_alu_b,
   input  logic [1:0]      i_dp_src_result,
   input  logic [3:0]      i_dp_alu_ctrl,
   input  logic            i_dp_reg_wr_en,
   output logic [XLEN-1:0] o_dp_instr,
   output logic            o_dp_alu_zero,
   output logic            o_dp_mem_done,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   input  logic            i_mem_ready,
   input  logic [XLEN-1:0] i_mem_rdata
);

   localparam int         SHW     = $clog2(XLEN);
   localparam int         RAW     = $clog2(NREGS);
   localparam logic [5:0] NREGS_W = 6'(NREGS);

   logic [XLEN-1:0] pc_q, oldpc_q, ir_q, a_q, b_q, aluout_q;
   logic [XLEN-1:0] alu_a, alu_b, alu_y, imm, result, mdr, rf_rd1, rf_rd2;
   logic [XLEN-1:0] rf [NREGS];
   logic signed [31:0] imm32;
   logic [4:0] rs1, rs2, rd;

   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign rd  = ir_q[11:7];

   // RV32E: indices at or above NREGS read as zero and are never written.
   assign rf_rd1 = (rs1 != '0 && {1'b0, rs1} < NREGS_W) ? rf[rs1[RAW-1:0]] : '0;
   assign rf_rd2 = (rs2 != '0 && {1'b0, rs2} < NREGS_W) ? rf[rs2[RAW-1:0]] : '0;

   // NOTE: the register array deliberately has no reset so it can map onto plain RAM; x0 is forced by the read mux.
   always_ff @(posedge i_clk) begin
      if (i_dp_reg_wr_en && rd != '0 && {1'b0, rd} < NREGS_W)
         rf[rd[RAW-1:0]] <= result;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_q     <= RESET_PC;
         oldpc_q  <= '0;
         ir_q     <= XLEN'(NOP_INSTR);
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
      end else begin
         a_q      <= rf_rd1;
         b_q      <= rf_rd2;
         aluout_q <= alu_y;
         if (i_dp_pc_wr_en) pc_q <= result;
         if (i_dp_ir_wr_en) begin
            ir_q    <= mdr;
            oldpc_q <= pc_q;
         end
      end
   end

   assign imm32 = imm_ext32(ir_q[31:0], i_dp_src_imm);
   assign imm   = XLEN'(imm32);

   always_comb begin
      alu_a = pc_q;
      case (i_dp_src_alu_a)
         ALU_A_OLDPC: alu_a = oldpc_q;
         ALU_A_REG:   alu_a = a_q;
         default:     alu_a = pc_q;
      endcase
      alu_b = b_q;
      case (i_dp_src_alu_b)
         ALU_B_IMM:  alu_b = imm;
         ALU_B_FOUR: alu_b = XLEN'(4);
         default:    alu_b = b_q;
      endcase
      alu_y = alu_a + alu_b;
      case (i_dp_alu_ctrl)
         ALU_SUB:    alu_y = alu_a - alu_b;
         ALU_AND:    alu_y = alu_a & alu_b;
         ALU_OR:     alu_y = alu_a | alu_b;
         ALU_XOR:    alu_y = alu_a ^ alu_b;
         ALU_SLL:    alu_y = alu_a << alu_b[SHW-1:0];
         ALU_SRL:    alu_y = alu_a >> alu_b[SHW-1:0];
         ALU_SRA:    alu_y = XLEN'($signed(alu_a) >>> alu_b[SHW-1:0]);
         ALU_SLT:    alu_y = XLEN'($signed(alu_a) < $signed(alu_b));
         ALU_SLTU:   alu_y = XLEN'(alu_a < alu_b);
         ALU_PASS_B: alu_y = alu_b;
         default:    alu_y = alu_a + alu_b;
      endcase
      result = aluout_q;
      case (i_dp_src_result)
         RES_MDR: result = mdr;
         RES_ALU: result = alu_y;
         default: result = aluout_q;
      endcase
   end

   assign o_dp_alu_zero = (alu_y == '0);
   assign o_dp_instr    = ir_q;

   riscv_mc_datapath_memif #(.XLEN(XLEN)) u_memif (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (i_dp_mem_req),
      .i_we        (i_dp_mem_we),
      .i_addr      (i_dp_addr_sel ? result : pc_q),
      .i_wdata     (b_q),
      .o_mdr       (mdr),
      .o_done      (o_dp_mem_done),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ready (i_mem_ready),
      .i_mem_rdata (i_mem_rdata)
   );

endmodule

// File: tb/tb_riscv_mc_datapath.sv
// Directed bench for riscv_mc_datapath (RV32E, RESET_PC=0x100): reset, fetch, stalled and
// back-to-back accesses, GPR writes, store, RV32E index masking, PC wrap and mid-access reset.
module tb_riscv_mc_datapath;
   import riscv_mc_datapath_pkg::*;

   localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_ADD_X2  = 32'h0010_8133; // add  x2,x1,x1
   localparam logic [31:0] I_ADD_X4  = 32'h0042_0233; // add  x4,x4,x4 (rd=4)
   localparam logic [31:0] I_SW_X4   = 32'h0241_2B23; // sw   x4,0x36(x2)
   localparam logic [31:0] I_ADD_X20 = 32'h0142_0A33; // add  x20,x4,x20

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_wr_en, ir_wr_en, addr_sel, dp_mem_req, dp_mem_we, reg_wr_en;
   logic [2:0]  src_imm;
   logic [1:0]  src_alu_a, src_alu_b, src_result;
   logic [3:0]  alu_ctrl;
   logic [31:0] instr, mem_addr, mem_wdata, mem_rdata;
   logic        alu_zero, mem_done, mem_req_o, mem_we_o, mem_ready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   riscv_mc_datapath #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0000_0100)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_dp_pc_wr_en(pc_wr_en), .i_dp_ir_wr_en(ir_wr_en), .i_dp_addr_sel(addr_sel),
      .i_dp_mem_req(dp_mem_req), .i_dp_mem_we(dp_mem_we), .i_dp_src_imm(src_imm),
      .i_dp_src_alu_a(src_alu_a), .i_dp_src_alu_b(src_alu_b), .i_dp_src_result(src_result),
      .i_dp_alu_ctrl(alu_ctrl), .i_dp_reg_wr_en(reg_wr_en),
      .o_dp_instr(instr), .o_dp_alu_zero(alu_zero), .o_dp_mem_done(mem_done),
      .o_mem_req(mem_req_o), .o_mem_we(mem_we_o), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Issues one access at the current negedge and returns at the negedge of the done cycle.
   task automatic mem_access(input logic sel, input logic we, input logic [31:0] rdata,
                             input int stall, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input bit poke);
      dp_mem_req = 1'b1;
      addr_sel   = sel;
      dp_mem_we  = we;
      @(negedge clk);
      dp_mem_req = 1'b0;
      pc_wr_en   = 1'b0;
      ir_wr_en   = 1'b0;
      reg_wr_en  = 1'b0;
      for (int i = 0; i <= stall; i++) begin
         check("mem_req_held", mem_req_o, 1);
         check("mem_addr", mem_addr, exp_addr);
         check("mem_we", mem_we_o, we);
         if (we) check("mem_wdata", mem_wdata, exp_wdata);
         check("done_early", mem_done, 0);
         mem_ready  = (i == stall);
         mem_rdata  = rdata;
         dp_mem_req = poke && (i == 1);
         @(negedge clk);
      end
      check("done_pulse", mem_done, 1);
      check("req_dropped", mem_req_o, 0);
      mem_ready  = 1'b0;
      dp_mem_req = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] word, input int stall, input bit poke);
      mem_access(1'b0, 1'b0, word, stall, pc, 32'h0, poke);
      ir_wr_en   = 1'b1;
      pc_wr_en   = 1'b1;
      src_alu_a  = ALU_A_PC;
      src_alu_b  = ALU_B_FOUR;
      alu_ctrl   = ALU_ADD;
      src_result = RES_ALU;
      @(negedge clk);
      ir_wr_en = 1'b0;
      pc_wr_en = 1'b0;
      check("ir_load", instr, word);
      check("done_once", mem_done, 0);
      check("req_idle", mem_req_o, 0);
   endtask

   initial begin
      rst = 1'b1;
      pc_wr_en = 1'b0; ir_wr_en = 1'b0; addr_sel = 1'b0; dp_mem_we = 1'b0; reg_wr_en = 1'b0;
      dp_mem_req = 1'b1;
      src_imm = IMM_I; src_alu_a = ALU_A_PC; src_alu_b = ALU_B_FOUR; src_result = RES_ALU;
      alu_ctrl = ALU_ADD; mem_ready = 1'b0; mem_rdata = 32'h0;

      repeat (3) begin
         @(negedge clk);
         check("rst_req", mem_req_o, 0);
         check("rst_done", mem_done, 0);
      end
      check("rst_ir", instr, 32'h0000_0013);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_we", mem_we_o, 0);
      rst = 1'b0;
      dp_mem_req = 1'b0;

      // NOP has rd=x0: try writing PC+4 into x0, then probe A+B (both x0).
      reg_wr_en = 1'b1;
      @(negedge clk);
      reg_wr_en = 1'b0;
      @(negedge clk);
      src_alu_a = ALU_A_REG; src_alu_b = ALU_B_REG; src_result = RES_ALU;
      mem_access(1'b1, 1'b0, 32'h0, 0, 32'h0, 32'h0, 1'b0);

      // Back-to-back fetch from RESET_PC; then addi x1,x0,5.
      fetch(32'h100, I_ADDI_X1, 0, 1'b0);
      @(negedge clk);
      src_alu_a = ALU_A_REG; src_alu_b = ALU_B_IMM; src_imm = IMM_I; alu_ctrl = ALU_ADD;
      src_result = RES_ALU; reg_wr_en = 1'b1;
      @(negedge clk);
      check("addi_zero", alu_zero, 0);
      reg_wr_en = 1'b0;

      // Stalled fetch with a second request while busy; then add x2,x1,x1.
      fetch(32'h104, I_ADD_X2, 5, 1'b1);
      @(negedge clk);
      src_alu_a = ALU_A_REG; src_alu_b = ALU_B_REG; alu_ctrl = ALU_ADD; reg_wr_en = 1'b1;
      @(negedge clk);
      reg_wr_en = 1'b0;
      alu_ctrl  = ALU_SUB;
      #1 check("sub_zero", alu_zero, 1);

      // Load 0xDEADBEEF from memory into x4.
      fetch(32'h108, I_ADD_X4, 0, 1'b0);
      mem_access(1'b0, 1'b0, 32'hDEAD_BEEF, 0, 32'h10C, 32'h0, 1'b0);
      src_result = RES_MDR;
      reg_wr_en  = 1'b1;
      @(negedge clk);
      reg_wr_en = 1'b0;

      // sw x4,0x36(x2): address 0x40 only if x2 holds 10; MDR must keep the fetched word.
      fetch(32'h10C, I_SW_X4, 0, 1'b0);
      @(negedge clk);
      src_alu_a = ALU_A_REG; src_alu_b = ALU_B_IMM; src_imm = IMM_S; alu_ctrl = ALU_ADD;
      @(negedge clk);
      src_result = RES_ALUOUT;
      mem_access(1'b1, 1'b1, 32'h1234_5678, 2, 32'h40, 32'hDEAD_BEEF, 1'b0);
      ir_wr_en = 1'b1;
      @(negedge clk);
      ir_wr_en = 1'b0;
      check("store_mdr_kept", instr, I_SW_X4);

      // RV32E: write to x20 must not alias x4, read of x20 must return 0.
      fetch(32'h110, I_ADD_X20, 0, 1'b0);
      @(negedge clk);
      src_alu_a = ALU_A_REG; src_alu_b = ALU_B_FOUR; alu_ctrl = ALU_SUB; src_result = RES_ALU;
      reg_wr_en = 1'b1;
      @(negedge clk);
      reg_wr_en = 1'b0;
      @(negedge clk);
      src_alu_b = ALU_B_REG; alu_ctrl = ALU_ADD;
      mem_access(1'b1, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 32'h0, 1'b0);

      // PC <- 0xFFFFFFFC via MDR (with back-to-back access), then PC+4 wraps to 0.
      mem_access(1'b0, 1'b0, 32'hFFFF_FFFC, 0, 32'h114, 32'h0, 1'b0);
      src_result = RES_MDR;
      pc_wr_en   = 1'b1;
      mem_access(1'b1, 1'b0, 32'h0, 0, 32'hFFFF_FFFC, 32'h0, 1'b0);
      src_alu_a = ALU_A_PC; src_alu_b = ALU_B_FOUR; alu_ctrl = ALU_ADD; src_result = RES_ALU;
      #1 check("wrap_zero", alu_zero, 1);
      pc_wr_en = 1'b1;
      @(negedge clk);
      pc_wr_en = 1'b0;
      mem_access(1'b0, 1'b0, 32'h0, 0, 32'h0, 32'h0, 1'b0);

      // Reset while busy aborts the access.
      dp_mem_req = 1'b1;
      addr_sel   = 1'b0;
      dp_mem_we  = 1'b0;
      @(negedge clk);
      dp_mem_req = 1'b0;
      check("abort_busy", mem_req_o, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_req", mem_req_o, 0);
      check("abort_done", mem_done, 0);
      check("abort_ir", instr, 32'h0000_0013);
      @(negedge clk);
      check("abort_no_done", mem_done, 0);
      check("abort_idle", mem_req_o, 0);
      mem_access(1'b0, 1'b0, 32'h0, 0, 32'h100, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
